// File: rtl/cpu_pkg.sv
// Shared types and encodings for the single-cycle RV32I core.
// ALU op enum, opcode and funct field constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv_alu.sv
// Combinational ALU for the single-cycle core.
// Shifts use b[4:0]; SLT compares signed.
module rv_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_t         i_alu_op,
  output logic [XLEN-1:0] o_result
);

  logic w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);

  // Select the result of the requested operation
  always_comb begin
    o_result = '0;
    unique case (i_alu_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLL: o_result = i_a << i_b[4:0];
      ALU_SRL: o_result = i_a >> i_b[4:0];
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, w_lt};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rv_single_cycle_cpu.sv
// Single-cycle RV32I ALU-subset core with ROM supplied as a port.
// Every datapath net is exported for combinational inspection.
module rv_single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ROM_WORDS     = 32,
  parameter int REG_INIT_BASE = 3000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     initial_instructions [ROM_WORDS],
  output logic [XLEN-1:0] pc_out_check,
  output logic [31:0]     instruction_check,
  output logic [2:0]      alu_op_check,
  output logic [XLEN-1:0] register_data_out1_check,
  output logic [XLEN-1:0] register_data_out2_check,
  output logic [XLEN-1:0] b_input_check,
  output logic [XLEN-1:0] register_data_in_check,
  output logic [XLEN-1:0] alu_result_check,
  output logic            reg_write_check,
  output logic [XLEN-1:0] imm_ext_check,
  output logic            use_imm_check,
  output logic [XLEN-1:0] register_check_arg [32]
);

  localparam int AW = $clog2(ROM_WORDS);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_regs [32];

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu_result;
  alu_op_t         w_alu_op;
  logic            w_use_imm;
  logic            w_reg_write;
  logic            w_f7_base;

  assign w_instr    = initial_instructions[r_pc[AW+1:2]];
  assign w_opcode   = w_instr[6:0];
  assign w_rd       = w_instr[11:7];
  assign w_funct3   = w_instr[14:12];
  assign w_rs1      = w_instr[19:15];
  assign w_rs2      = w_instr[24:20];
  assign w_funct7   = w_instr[31:25];
  assign w_f7_base  = (w_funct7 == F7_BASE);
  assign w_imm_ext  = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign w_b        = w_use_imm ? w_imm_ext : w_rs2_data;

  // Decode opcode/funct fields into ALU op and control bits
  always_comb begin
    w_alu_op    = ALU_ADD;
    w_use_imm   = 1'b0;
    w_reg_write = 1'b0;
    unique case (1'b1)
      (w_opcode == OP_R): begin
        w_reg_write = w_f7_base;
        case (w_funct3)
          F3_ADD: begin
            if (w_funct7 == F7_ALT) begin
              w_alu_op    = ALU_SUB;
              w_reg_write = 1'b1;
            end
          end
          F3_SLL:  w_alu_op = ALU_SLL;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_SRL:  w_alu_op = ALU_SRL;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          default: w_reg_write = 1'b0;
        endcase
      end
      (w_opcode == OP_I): begin
        w_use_imm   = 1'b1;
        w_reg_write = 1'b1;
        case (w_funct3)
          F3_ADD: w_alu_op = ALU_ADD;
          F3_SLT: w_alu_op = ALU_SLT;
          F3_XOR: w_alu_op = ALU_XOR;
          F3_OR:  w_alu_op = ALU_OR;
          F3_AND: w_alu_op = ALU_AND;
          F3_SLL: begin
            w_alu_op    = ALU_SLL;
            w_reg_write = w_f7_base;
          end
          F3_SRL: begin
            w_alu_op    = ALU_SRL;
            w_reg_write = w_f7_base;
          end
          default: w_reg_write = 1'b0;
        endcase
      end
      default: begin
        w_alu_op    = ALU_ADD;
        w_use_imm   = 1'b0;
        w_reg_write = 1'b0;
      end
    endcase
  end

  rv_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .i_a      (w_rs1_data),
    .i_b      (w_b),
    .i_alu_op (w_alu_op),
    .o_result (w_alu_result)
  );

  // PC advances every cycle; no control transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pc <= '0;
    else        r_pc <= r_pc + XLEN'(4);
  end

  // Register file: seeded base+i, x0 never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= (i == 0) ? '0 : XLEN'(REG_INIT_BASE + i);
    end else if (w_reg_write && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_alu_result;
    end
  end

  // Export register contents with x0 pinned to zero
  always_comb begin
    for (int i = 0; i < 32; i++)
      register_check_arg[i] = (i == 0) ? '0 : r_regs[i];
  end

  assign pc_out_check             = r_pc;
  assign instruction_check        = w_instr;
  assign alu_op_check             = w_alu_op;
  assign register_data_out1_check = w_rs1_data;
  assign register_data_out2_check = w_rs2_data;
  assign b_input_check            = w_b;
  assign register_data_in_check   = w_alu_result;
  assign alu_result_check         = w_alu_result;
  assign reg_write_check          = w_reg_write;
  assign imm_ext_check            = w_imm_ext;
  assign use_imm_check            = w_use_imm;

endmodule

// File: tb/tb_rv_single_cycle_cpu.sv
// Directed bench for rv_single_cycle_cpu and rv_alu.
// Expected values are hand-computed from the program below.
module tb_rv_single_cycle_cpu;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom [32];
  logic [31:0] pc, instr, out1, out2, bin, din, res, imm;
  logic [2:0]  aop;
  logic        rw, uimm;
  logic [31:0] regs [32];
  logic [31:0] exp_regs [32];

  logic [31:0] a_a, a_b, a_res;
  alu_op_t     a_op;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv_single_cycle_cpu dut (
    .clk                      (clk),
    .reset                    (reset),
    .initial_instructions     (rom),
    .pc_out_check             (pc),
    .instruction_check        (instr),
    .alu_op_check             (aop),
    .register_data_out1_check (out1),
    .register_data_out2_check (out2),
    .b_input_check            (bin),
    .register_data_in_check   (din),
    .alu_result_check         (res),
    .reg_write_check          (rw),
    .imm_ext_check            (imm),
    .use_imm_check            (uimm),
    .register_check_arg       (regs)
  );

  rv_alu u_alu (
    .i_a      (a_a),
    .i_b      (a_b),
    .i_alu_op (a_op),
    .o_result (a_res)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++)
      exp_regs[i] = (i == 0) ? 32'd0 : 32'(3000 + i);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s x%0d", tag, i), regs[i], exp_regs[i]);
  endtask

  logic [31:0] alu_exp [8];

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'd0;
    rom[0] = 32'h005303b3;
    rom[1] = 32'h40848533;
    rom[2] = 32'h00160693;
    rom[3] = 32'h00000000;
    rom[4] = 32'h00530033;
    rom[5] = 32'hfff0a713;
    rom[6] = 32'h40849533;
    reset_model();
    a_a = 32'd0;
    a_b = 32'd0;
    a_op = ALU_ADD;

    #12;
    check("rst pc", pc, 32'd0);
    check("rst instr", instr, 32'h005303b3);
    check_regs("rst");
    reset = 1'b1;
    #1;

    check("add op", {29'd0, aop}, 32'd0);
    check("add out1", out1, 32'd3006);
    check("add out2", out2, 32'd3005);
    check("add res", res, 32'd6011);
    check("add din", din, 32'd6011);
    check("add uimm", {31'd0, uimm}, 32'd0);
    check("add rw", {31'd0, rw}, 32'd1);

    step();
    exp_regs[7] = 32'd6011;
    check("sub pc", pc, 32'd4);
    check("sub instr", instr, 32'h40848533);
    check("x7 wb", regs[7], 32'd6011);
    check("sub op", {29'd0, aop}, 32'd1);
    check("sub out1", out1, 32'd3009);
    check("sub out2", out2, 32'd3008);
    check("sub res", res, 32'd1);
    check("sub uimm", {31'd0, uimm}, 32'd0);

    step();
    exp_regs[10] = 32'd1;
    check("addi pc", pc, 32'd8);
    check("addi op", {29'd0, aop}, 32'd0);
    check("addi imm", imm, 32'd1);
    check("addi uimm", {31'd0, uimm}, 32'd1);
    check("addi out1", out1, 32'd3012);
    check("addi b", bin, 32'd1);
    check("addi res", res, 32'd3013);

    step();
    exp_regs[13] = 32'd3013;
    check("nop pc", pc, 32'd12);
    check("nop instr", instr, 32'd0);
    check("nop rw", {31'd0, rw}, 32'd0);
    check("nop uimm", {31'd0, uimm}, 32'd0);
    check("nop op", {29'd0, aop}, 32'd0);
    check_regs("pc12");

    step();
    check("x0w pc", pc, 32'd16);
    check_regs("nop");
    check("x0w rw", {31'd0, rw}, 32'd1);
    check("x0w res", res, 32'd6011);

    step();
    check("slti pc", pc, 32'd20);
    check("x0 stays", regs[0], 32'd0);
    check("slti imm", imm, 32'hffffffff);
    check("slti b", bin, 32'hffffffff);
    check("slti op", {29'd0, aop}, 32'd7);
    check("slti res", res, 32'd0);
    check("slti rw", {31'd0, rw}, 32'd1);

    step();
    exp_regs[14] = 32'd0;
    check("bad pc", pc, 32'd24);
    check("x14", regs[14], 32'd0);
    check("bad rw", {31'd0, rw}, 32'd0);

    step();
    check("post pc", pc, 32'd28);
    check_regs("post");

    #2;
    reset = 1'b0;
    #1;
    reset_model();
    check("async pc", pc, 32'd0);
    check("async x7", regs[7], 32'd3007);
    check("async x10", regs[10], 32'd3010);
    check("async instr", instr, 32'h005303b3);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) step();
    check("wrap pc", pc, 32'd128);
    check("alias instr", instr, 32'h005303b3);

    alu_exp = '{32'd6, 32'd2, 32'd0, 32'd6,
                32'd6, 32'd16, 32'd1, 32'd0};
    a_a = 32'd4;
    a_b = 32'd2;
    for (int k = 0; k < 8; k++) begin
      a_op = alu_op_t'(k);
      #1;
      check($sformatf("alu op%0d", k), a_res, alu_exp[k]);
    end
    a_a = 32'hffffffff;
    a_b = 32'd0;
    a_op = ALU_SLT;
    #1;
    check("slt neg", a_res, 32'd1);
    a_a = 32'd1;
    a_b = 32'hffffffff;
    #1;
    check("slt pos", a_res, 32'd0);
    a_a = 32'h80000000;
    a_b = 32'd31;
    a_op = ALU_SRL;
    #1;
    check("srl logic", a_res, 32'd1);
    a_b = 32'd33;
    a_op = ALU_SLL;
    a_a = 32'd1;
    #1;
    check("sll b40", a_res, 32'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rv_single_cycle_cpu.md
Name: rv_single_cycle_cpu

Overview:
- Single-cycle RV32I integer subset core: fetch, decode, execute and write-back each complete in one clock.
- Instruction ROM contents are supplied as a port.
- Exposes internal datapath nets as debug ports so directed benches can check each stage combinationally.
- Sits as the top of the teaching CPU; composed of PC, PC+4 adder, ROM, register file, sign-extender and ALU.

Parameters:
- XLEN, 32, datapath and register width.
- ROM_WORDS, 32, instruction ROM depth in words.
- REG_INIT_BASE, 3000, reset value base: register xi resets to REG_INIT_BASE+i for i=1..31.

Ports:
- clk  in  1  sole clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- initial_instructions  in  32x32  ROM word i at byte address 4*i.
- pc_out_check  out  32  current PC.
- instruction_check  out  32  ROM word at PC.
- alu_op_check  out  3  decoded ALU operation.
- register_data_out1_check  out  32  rs1 read data.
- register_data_out2_check  out  32  rs2 read data.
- b_input_check  out  32  ALU operand B after immediate mux.
- register_data_in_check  out  32  write-back data (equals ALU result).
- alu_result_check  out  32  ALU result.
- reg_write_check  out  1  register write enable.
- imm_ext_check  out  32  sign-extended instr[31:20].
- use_imm_check  out  1  operand B selects the immediate.
- register_check_arg  out  32x32  live contents of x0..x31.

Behaviour:
- Reset (reset=0, asynchronous): PC=0; x0=0; xi=REG_INIT_BASE+i for i=1..31. All debug outputs are combinational from this state, e.g. instruction_check = ROM[0].
- Each rising clk with reset=1: PC <= PC+4 (32-bit wrap); if reg_write and rd!=0, x[rd] <= ALU result. No branches or jumps.
- Fetch: instruction = initial_instructions[PC[6:2]]. PC[1:0] ignored; addresses beyond 124 alias modulo 128.
- Register reads are combinational. x0 always reads 0. Register writes are visible the cycle after the edge; no write-through bypass.
- imm_ext = {{20{instr[31]}}, instr[31:20]}.
- ALU ops (3-bit, package enum): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7.
  - Shifts use b[4:0].
  - SLT is signed: result = 1 if a<b else 0.
  - Arithmetic wraps mod 2^32.
- Decode, opcode 0110011 (R-type), use_imm=0, reg_write=1:
  - funct3 000: ADD, or SUB if funct7=0100000.
  - 001 SLL, 010 SLT, 100 XOR, 101 SRL (funct7=0), 110 OR, 111 AND.
  - Any other funct3/funct7 combination: reg_write=0.
- Decode, opcode 0010011 (I-type ALU), use_imm=1, reg_write=1:
  - 000 ADDI, 010 SLTI, 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI and 101 SRLI require instr[31:25]=0; otherwise reg_write=0.
- Any other opcode, including all-zero words: NOP. reg_write=0, alu_op=ADD, use_imm=0; PC still advances.
- b_input = use_imm ? imm_ext : rs2 data.
- register_data_in = ALU result.
- reset asserted mid-run: state returns to reset values immediately, independent of clk.

Decomposition:
- Package cpu_pkg holds the alu_op_t enum (values above), opcode constants OP_R=7'b0110011 and OP_I=7'b0010011, and the funct3/funct7 constants.
- Natural sub-module: rv_alu (a, b, alu_op -> result), purely combinational.
- Register file, ROM mux, decoder and sign-extend are inline in the top.

Test Plan:
- ROM[0..2] = 0x005303b3 (add x7,x6,x5), 0x40848533 (sub x10,x9,x8), 0x00160693 (addi x13,x12,1); assert then release reset.
  - PC=0: alu_op=ADD, out1=3006, out2=3005, result=6011, use_imm=0.
  - After the edge: x7=6011.
- Second edge -> PC=4, instruction=0x40848533, alu_op=SUB, out1=3009, out2=3008, result=1, use_imm=0.
- Third edge -> PC=8, alu_op=ADD, imm_ext=1, use_imm=1, out1=3012, b_input=1, result=3013. Next edge x13=3013.
- Standalone rv_alu with a=4, b=2 -> ADD 6, SUB 2, AND 0, OR 6, XOR 6, SLL 16, SRL 1, SLT 0. Also a=-1, b=0 with SLT -> 1.
- Zero instruction at PC=12: reg_write=0, no register changes, PC becomes 16.
- Write to x0 (e.g. add x0,x6,x5): x0 stays 0. Pulse reset low mid-run: PC=0 and x7=3007 asynchronously.
